fadd_norm_round_pipe: RTL

Pipelined back end of the single-precision FADD/FSUB unit. It consumes the already-aligned operands from the extract/align stage:
- signs, with the subtract already folded into `sign2`
- common exponent
- 48-bit aligned mantissas
- special-case flags

It performs the signed magnitude add/subtract, normalization, and IEEE-754 rounding, and delivers a packed binary32 result with RISC-V `fflags`. It sits between the align stage and the FPU writeback mux, behind a valid/ready handshake so the FPU can stall it.

---
 rtl/fadd_norm_round_pipe.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fadd_norm_round_pipe.sv
// Three-stage back end of the binary32 adder: signed magnitude add, normalize, round/pack.
// Valid/ready pipeline; every stage advances when the stage after it is empty or advancing.
module fadd_norm_round_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  rm,
    input  logic        sign1,
    input  logic        sign2,
    input  logic [7:0]  exp_res,
    input  logic [47:0] man1_al,
    input  logic [47:0] man2_al,
    input  logic        nan,
    input  logic        inf1,
    input  logic        inf2,
    input  logic        zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  fflags
);
    localparam int unsigned MAN_W = 48;
    localparam int unsigned EXP_W = 8;
    localparam logic [2:0]  RM_RNE = 3'd0;
    localparam logic [2:0]  RM_RTZ = 3'd1;
    localparam logic [2:0]  RM_RDN = 3'd2;
    localparam logic [2:0]  RM_RUP = 3'd3;
    localparam logic [2:0]  RM_RMM = 3'd4;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    localparam logic [31:0] MAXFIN = 32'h7F7F_FFFF;

    typedef struct packed {
        logic [MAN_W-1:0] sum;
        logic             sgn;
        logic [EXP_W-1:0] exp;
        logic [2:0]       rm;
        logic             spec;
        logic [31:0]      spec_res;
        logic             spec_nv;
    } s1_t;

    typedef struct packed {
        logic [MAN_W-1:0] man;
        logic             sgn;
        logic [EXP_W:0]   exp;
        logic [2:0]       rm;
        logic             spec;
        logic [31:0]      spec_res;
        logic             spec_nv;
    } s2_t;

    // The align stage already classified zeros; the sum itself is authoritative here.
    logic unused_zero;
    assign unused_zero = zero;

    s1_t s1_q, s1_c;
    s2_t s2_q, s2_c;
    logic        s1_valid, s2_valid;
    logic        s1_ready, s2_ready, s3_ready;
    logic [31:0] res_c;
    logic [4:0]  flags_c;

    assign s3_ready = ~out_valid | out_ready;
    assign s2_ready = ~s2_valid | s3_ready;
    assign s1_ready = ~s1_valid | s2_ready;
    assign in_ready = s1_ready;

    function automatic logic [5:0] lzc46(input logic [46:0] v);
        lzc46 = 6'd47;
        for (int i = 0; i <= 46; i++) begin
            if (v[i]) lzc46 = 6'(46 - i);
        end
    endfunction

    // Stage 1: magnitude add/subtract and special-case resolution.
    always_comb begin
        s1_c     = '0;
        s1_c.rm  = (rm > RM_RMM) ? RM_RNE : rm;
        s1_c.exp = exp_res;
        if (sign1 == sign2) begin
            s1_c.sum = MAN_W'(man1_al + man2_al);
            s1_c.sgn = sign1;
        end else if (man1_al > man2_al) begin
            s1_c.sum = MAN_W'(man1_al - man2_al);
            s1_c.sgn = sign1;
        end else if (man2_al > man1_al) begin
            s1_c.sum = MAN_W'(man2_al - man1_al);
            s1_c.sgn = sign2;
        end else begin
            s1_c.sum = '0;
            s1_c.sgn = (s1_c.rm == RM_RDN);
        end
        s1_c.spec = nan | inf1 | inf2;
        if (nan) begin
            s1_c.spec_res = QNAN;
        end else if (inf1 & inf2 & (sign1 != sign2)) begin
            s1_c.spec_res = QNAN;
            s1_c.spec_nv  = 1'b1;
        end else if (inf1) begin
            s1_c.spec_res = {sign1, 8'hFF, 23'd0};
        end else begin
            s1_c.spec_res = {sign2, 8'hFF, 23'd0};
        end
    end

    // Stage 2: normalize, limited so a tiny result stays at effective exponent 1.
    logic [7:0] eff_exp, shamt, lim;
    logic [7:0] lz8;
    always_comb begin
        s2_c          = '0;
        s2_c.sgn      = s1_q.sgn;
        s2_c.rm       = s1_q.rm;
        s2_c.spec     = s1_q.spec;
        s2_c.spec_res = s1_q.spec_res;
        s2_c.spec_nv  = s1_q.spec_nv;
        eff_exp       = (s1_q.exp == 8'd0) ? 8'd1 : s1_q.exp;
        lim           = eff_exp - 8'd1;
        lz8           = {2'b00, lzc46(s1_q.sum[46:0])};
        shamt         = (lz8 < lim) ? lz8 : lim;
        if (s1_q.sum[47]) begin
            s2_c.man = {1'b0, s1_q.sum[47:2], s1_q.sum[1] | s1_q.sum[0]};
            s2_c.exp = 9'(eff_exp) + 9'd1;
        end else if (s1_q.sum == '0) begin
            s2_c.man = '0;
            s2_c.exp = '0;
        end else begin
            s2_c.man = s1_q.sum << shamt;
            s2_c.exp = s2_c.man[46] ? 9'(eff_exp - shamt) : 9'd0;
        end
    end

    // Stage 3: round, detect overflow/underflow, pack, apply specials.
    logic [23:0] sig;
    logic [24:0] sig_r;
    logic [9:0]  exp_r;
    logic        g, r, st, nx, up, tiny, to_inf;
    always_comb begin
        sig    = s2_q.man[46:23];
        g      = s2_q.man[22];
        r      = s2_q.man[21];
        st     = |s2_q.man[20:0];
        nx     = g | r | st;
        tiny   = (s2_q.exp == 9'd0) && (s2_q.man != '0);
        case (s2_q.rm)
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = nx & s2_q.sgn;
            RM_RUP:  up = nx & ~s2_q.sgn;
            RM_RMM:  up = g;
            default: up = g & (r | st | sig[0]);
        endcase
        sig_r = {1'b0, sig} + 25'(up);
        exp_r = {1'b0, s2_q.exp};
        if (sig_r[24]) begin
            sig_r = sig_r >> 1;
            exp_r = exp_r + 10'd1;
        end else if ((s2_q.exp == 9'd0) && sig_r[23]) begin
            exp_r = 10'd1;
        end
        to_inf = (s2_q.rm == RM_RNE) | (s2_q.rm == RM_RMM) |
                 ((s2_q.rm == RM_RUP) & ~s2_q.sgn) | ((s2_q.rm == RM_RDN) & s2_q.sgn);
        if (s2_q.spec) begin
            res_c   = s2_q.spec_res;
            flags_c = {s2_q.spec_nv, 4'b0000};
        end else if (exp_r >= 10'd255) begin
            res_c   = to_inf ? {s2_q.sgn, 8'hFF, 23'd0} : {s2_q.sgn, MAXFIN[30:0]};
            flags_c = 5'b00101;
        end else begin
            res_c   = {s2_q.sgn, exp_r[7:0], sig_r[22:0]};
            flags_c = {3'b000, tiny & nx, nx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            result    <= '0;
            fflags    <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= in_valid;
                if (in_valid) s1_q <= s1_c;
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_q <= s2_c;
            end
            if (s3_ready) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    result <= res_c;
                    fflags <= flags_c;
                end
            end
        end
    end
endmodule
